// File: rtl/mem_abc_responder_if.sv
// Request/response bundle between the SUBLEQ control path and its memory.
// master: drives strobes, addresses, write and preload data; slave: returns words + status.
//   read_en_abc/read_en_ab/write_en_b : request strobes
//   pc/addr_a/addr_b/wdata            : request operands
//   init_we/init_addr/init_data       : preload port
//   a_out/b_out/c_out                 : fetched instruction words
//   mem_a_out/mem_b_out               : fetched operand words
//   busy/done/err                     : status (level, pulse, pulse)
interface mem_abc_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              read_en_abc;
    logic              read_en_ab;
    logic              write_en_b;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [DATA_W-1:0] c_out;
    logic [DATA_W-1:0] mem_a_out;
    logic [DATA_W-1:0] mem_b_out;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output read_en_abc,
        output read_en_ab,
        output write_en_b,
        output pc,
        output addr_a,
        output addr_b,
        output wdata,
        output init_we,
        output init_addr,
        output init_data,
        input  a_out,
        input  b_out,
        input  c_out,
        input  mem_a_out,
        input  mem_b_out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  read_en_abc,
        input  read_en_ab,
        input  write_en_b,
        input  pc,
        input  addr_a,
        input  addr_b,
        input  wdata,
        input  init_we,
        input  init_addr,
        input  init_data,
        output a_out,
        output b_out,
        output c_out,
        output mem_a_out,
        output mem_b_out,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/mem_abc_responder.sv
// Memory-side responder for the SUBLEQ ABC datapath: a single-port word array
// serving instruction fetch (3 words), operand fetch (2 words) and writeback.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (array contents are retained)
//   bus  : mem_abc_responder_if.slave (request strobes, operands, preload,
//          registered read outputs, busy/done/err status)
module mem_abc_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_abc_responder_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        O0   = 3'd4,
        O1   = 3'd5,
        W0   = 3'd6
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_la;
    logic [ADDR_W-1:0] r_lb;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] r_ma;
    logic [DATA_W-1:0] r_mb;
    logic              r_done;
    logic              r_err;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_any_req;
    logic              w_any_op;
    logic [2:0]        w_nreq;
    logic              w_multi;
    logic              w_init_ok;
    logic              w_wb_commit;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_idle    = (r_state == IDLE);
    assign w_any_op  = bus.read_en_abc | bus.read_en_ab | bus.write_en_b;
    assign w_any_req = w_any_op | bus.init_we;

    // More than one strobe in IDLE means something gets dropped.
    assign w_nreq = 3'(bus.read_en_abc) + 3'(bus.read_en_ab)
                  + 3'(bus.write_en_b) + 3'(bus.init_we);
    assign w_multi = (w_nreq > 3'd1);

    // Preload only lands when it is the sole strobe in IDLE.
    assign w_init_ok   = w_idle & bus.init_we & ~w_any_op;
    assign w_wb_commit = (r_state == W0);

    // One shared read port; the state picks which latched address drives it.
    // r_base is advanced during the fetch, so it already points at the
    // next word in F1/F2 and wraps naturally at ADDR_W bits.
    always_comb begin
        w_raddr = r_base;
        unique case (r_state)
            O0:      w_raddr = r_la;
            O1:      w_raddr = r_lb;
            default: w_raddr = r_base;
        endcase
    end

    assign w_rdata = r_mem[w_raddr];

    // Array has no reset so contents survive rst.  While rst is high the
    // state is IDLE, so an interrupted writeback never commits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wb_commit) begin
                r_mem[r_lb] <= r_wdata;
            end else if (w_init_ok) begin
                r_mem[bus.init_addr] <= bus.init_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_la    <= '0;
            r_lb    <= '0;
            r_wdata <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_err <= w_multi;
                    if (bus.write_en_b) begin
                        r_lb    <= bus.addr_b;
                        r_wdata <= bus.wdata;
                        r_state <= W0;
                    end else if (bus.read_en_ab) begin
                        r_la    <= bus.addr_a;
                        r_lb    <= bus.addr_b;
                        r_state <= O0;
                    end else if (bus.read_en_abc) begin
                        r_base  <= bus.pc;
                        r_state <= F0;
                    end
                end
                F0: begin
                    r_a     <= w_rdata;
                    r_base  <= r_base + ONE;
                    r_state <= F1;
                    r_err   <= w_any_req;
                end
                F1: begin
                    r_b     <= w_rdata;
                    r_base  <= r_base + ONE;
                    r_state <= F2;
                    r_err   <= w_any_req;
                end
                F2: begin
                    r_c     <= w_rdata;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    r_err   <= w_any_req;
                end
                O0: begin
                    r_ma    <= w_rdata;
                    r_state <= O1;
                    r_err   <= w_any_req;
                end
                O1: begin
                    r_mb    <= w_rdata;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    r_err   <= w_any_req;
                end
                W0: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    r_err   <= w_any_req;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = ~w_idle;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.c_out     = r_c;
    assign bus.mem_a_out = r_ma;
    assign bus.mem_b_out = r_mb;

endmodule

// File: tb/tb_mem_abc_responder.sv
// Self-checking bench for mem_abc_responder: directed scenarios plus random
// traffic compared against an array-based reference of memory and outputs.
module tb_mem_abc_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_abc_responder_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    mem_abc_responder #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] e_a, e_b, e_c, e_ma, e_mb;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_req();
        bus.read_en_abc = 1'b0;
        bus.read_en_ab  = 1'b0;
        bus.write_en_b  = 1'b0;
        bus.init_we     = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.init_we   = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        @(negedge clk);
        bus.init_we   = 1'b0;
        ref_mem[a] = d;
    endtask

    // Waits from the request edge to done; lat is edges after the request edge.
    task automatic run_txn(output int lat, output int nbusy, output int nerr);
        lat = -1;
        nbusy = 0;
        nerr = 0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) clear_req();
            if (bus.err) nerr++;
            if (bus.done) begin
                lat = k - 1;
                break;
            end
            if (bus.busy) nbusy++;
        end
    endtask

    task automatic do_fetch(input logic [7:0] p,
                            output int lat, output int nb, output int ne);
        logic [7:0] p1, p2;
        @(negedge clk);
        bus.read_en_abc = 1'b1;
        bus.pc = p;
        run_txn(lat, nb, ne);
        p1 = p + 8'd1;
        p2 = p + 8'd2;
        e_a = ref_mem[p];
        e_b = ref_mem[p1];
        e_c = ref_mem[p2];
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output int nb, output int ne);
        @(negedge clk);
        bus.read_en_ab = 1'b1;
        bus.addr_a = a;
        bus.addr_b = b;
        run_txn(lat, nb, ne);
        e_ma = ref_mem[a];
        e_mb = ref_mem[b];
    endtask

    task automatic do_write(input logic [7:0] b, input logic [15:0] d,
                            output int lat, output int nb, output int ne);
        @(negedge clk);
        bus.write_en_b = 1'b1;
        bus.addr_b = b;
        bus.wdata = d;
        run_txn(lat, nb, ne);
        ref_mem[b] = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out});
        end
        n_tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.done, bus.err});
        end
        rst = 1'b0;
        e_a = 0; e_b = 0; e_c = 0; e_ma = 0; e_mb = 0;
    endtask

    task automatic test_fetch();
        int lat, nb, ne;
        preload(8'd10, 16'd3);
        preload(8'd11, 16'd7);
        preload(8'd12, 16'd20);
        do_fetch(8'd10, lat, nb, ne);
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out} !== {16'd3, 16'd7, 16'd20}) begin
            n_fail++;
            $display("FAIL fetch_abc: got %0d/%0d/%0d expected 3/7/20",
                     bus.a_out, bus.b_out, bus.c_out);
        end
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d expected 3", lat);
        end
        n_tests++;
        if (nb !== 3) begin
            n_fail++;
            $display("FAIL fetch_busy_cycles: got %0d expected 3", nb);
        end
        n_tests++;
        if (ne !== 0) begin
            n_fail++;
            $display("FAIL fetch_err: got %0d expected 0", ne);
        end
    endtask

    task automatic test_wrap();
        int lat, nb, ne;
        preload(8'd255, 16'd1);
        preload(8'd0, 16'd2);
        preload(8'd1, 16'd4);
        do_fetch(8'd255, lat, nb, ne);
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out} !== {16'd1, 16'd2, 16'd4}) begin
            n_fail++;
            $display("FAIL wrap_abc: got %0d/%0d/%0d expected 1/2/4",
                     bus.a_out, bus.b_out, bus.c_out);
        end
    endtask

    task automatic test_operand_write();
        int lat, nb, ne;
        preload(8'd3, 16'd5);
        preload(8'd7, 16'd9);
        do_read(8'd3, 8'd7, lat, nb, ne);
        n_tests++;
        if ({bus.mem_a_out, bus.mem_b_out} !== {16'd5, 16'd9}) begin
            n_fail++;
            $display("FAIL operand_read: got %0d/%0d expected 5/9",
                     bus.mem_a_out, bus.mem_b_out);
        end
        n_tests++;
        if (lat !== 2 || nb !== 2) begin
            n_fail++;
            $display("FAIL operand_latency: got lat %0d busy %0d expected 2/2", lat, nb);
        end
        do_write(8'd7, 16'hFFFC, lat, nb, ne);
        n_tests++;
        if (lat !== 1 || nb !== 1) begin
            n_fail++;
            $display("FAIL write_latency: got lat %0d busy %0d expected 1/1", lat, nb);
        end
        do_read(8'd7, 8'd7, lat, nb, ne);
        n_tests++;
        if ({bus.mem_a_out, bus.mem_b_out} !== {16'hFFFC, 16'hFFFC}) begin
            n_fail++;
            $display("FAIL readback_same_addr: got %h/%h expected fffc/fffc",
                     bus.mem_a_out, bus.mem_b_out);
        end
    endtask

    task automatic test_conflict();
        int lat, nb, ne;
        logic [15:0] old_ma;
        preload(8'd20, 16'h0AAA);
        preload(8'd21, 16'h0BBB);
        old_ma = bus.mem_a_out;
        @(negedge clk);
        bus.read_en_ab = 1'b1;
        bus.write_en_b = 1'b1;
        bus.addr_a = 8'd20;
        bus.addr_b = 8'd21;
        bus.wdata = 16'h1234;
        run_txn(lat, nb, ne);
        ref_mem[21] = 16'h1234;
        n_tests++;
        if (lat !== 1 || ne !== 1) begin
            n_fail++;
            $display("FAIL conflict_write_only: got lat %0d err %0d expected 1/1", lat, ne);
        end
        n_tests++;
        if (bus.mem_a_out !== old_ma) begin
            n_fail++;
            $display("FAIL conflict_ma_hold: got %h expected %h", bus.mem_a_out, old_ma);
        end
        do_read(8'd21, 8'd21, lat, nb, ne);
        n_tests++;
        if (bus.mem_b_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL conflict_written: got %h expected 1234", bus.mem_b_out);
        end
    endtask

    task automatic test_busy_strobe();
        int lat, nerr;
        logic [7:0] p1, p2;
        logic [15:0] old50;
        int nb, ne;
        old50 = ref_mem[50];
        lat = -1;
        nerr = 0;
        @(negedge clk);
        bus.read_en_abc = 1'b1;
        bus.pc = 8'd40;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.err) nerr++;
            if (bus.done) begin
                lat = k - 1;
                break;
            end
            if (k == 1) clear_req();
            if (k == 2) begin
                bus.read_en_abc = 1'b1;
                bus.pc = 8'd99;
                bus.init_we = 1'b1;
                bus.init_addr = 8'd50;
                bus.init_data = ~old50;
            end
            if (k == 3) clear_req();
        end
        p1 = 8'd41;
        p2 = 8'd42;
        e_a = ref_mem[40];
        e_b = ref_mem[p1];
        e_c = ref_mem[p2];
        n_tests++;
        if (lat !== 3 || nerr !== 1) begin
            n_fail++;
            $display("FAIL busy_strobe_err: got lat %0d err %0d expected 3/1", lat, nerr);
        end
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out} !== {e_a, e_b, e_c}) begin
            n_fail++;
            $display("FAIL busy_strobe_fetch: got %h/%h/%h expected %h/%h/%h",
                     bus.a_out, bus.b_out, bus.c_out, e_a, e_b, e_c);
        end
        do_read(8'd50, 8'd50, lat, nb, ne);
        n_tests++;
        if (bus.mem_a_out !== old50) begin
            n_fail++;
            $display("FAIL busy_init_ignored: got %h expected %h", bus.mem_a_out, old50);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, ne, ndone;
        logic [15:0] old70;
        @(negedge clk);
        bus.read_en_abc = 1'b1;
        bus.pc = 8'd60;
        @(posedge clk);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        e_a = 0; e_b = 0; e_c = 0; e_ma = 0; e_mb = 0;
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out, bus.busy} !== 81'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h busy %b expected 0",
                     {bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out}, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d expected 0", ndone);
        end
        do_fetch(8'd60, lat, nb, ne);
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.c_out} !== {e_a, e_b, e_c}) begin
            n_fail++;
            $display("FAIL midreset_refetch: got %h/%h/%h expected %h/%h/%h",
                     bus.a_out, bus.b_out, bus.c_out, e_a, e_b, e_c);
        end
        old70 = ref_mem[70];
        @(negedge clk);
        bus.write_en_b = 1'b1;
        bus.addr_b = 8'd70;
        bus.wdata = ~old70;
        @(posedge clk);
        @(negedge clk);
        clear_req();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_a = 0; e_b = 0; e_c = 0; e_ma = 0; e_mb = 0;
        do_read(8'd70, 8'd70, lat, nb, ne);
        n_tests++;
        if (bus.mem_b_out !== old70) begin
            n_fail++;
            $display("FAIL midreset_write_aborted: got %h expected %h", bus.mem_b_out, old70);
        end
    endtask

    task automatic test_random();
        int lat, nb, ne, op, exp_lat;
        logic [7:0] x, y;
        logic [15:0] d;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            x = 8'($urandom);
            y = 8'($urandom);
            d = 16'($urandom);
            exp_lat = -1;
            ne = 0;
            case (op)
                0: begin do_fetch(x, lat, nb, ne); exp_lat = 3; end
                1: begin do_read(x, y, lat, nb, ne); exp_lat = 2; end
                2: begin do_write(y, d, lat, nb, ne); exp_lat = 1; end
                default: preload(x, d);
            endcase
            if (exp_lat >= 0) begin
                n_tests++;
                if (lat !== exp_lat || ne !== 0) begin
                    n_fail++;
                    $display("FAIL rand_latency op%0d: got lat %0d err %0d expected %0d/0",
                             op, lat, ne, exp_lat);
                end
            end
            n_tests++;
            if ({bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out}
                !== {e_a, e_b, e_c, e_ma, e_mb}) begin
                n_fail++;
                $display("FAIL rand_outputs op%0d: got %h expected %h", op,
                         {bus.a_out, bus.b_out, bus.c_out, bus.mem_a_out, bus.mem_b_out},
                         {e_a, e_b, e_c, e_ma, e_mb});
            end
        end
    endtask

    initial begin
        bus.pc = '0;
        bus.addr_a = '0;
        bus.addr_b = '0;
        bus.wdata = '0;
        bus.init_addr = '0;
        bus.init_data = '0;
        clear_req();
        test_reset();
        for (int i = 0; i < 256; i++) begin
            preload(8'(i), 16'($urandom));
        end
        test_fetch();
        test_wrap();
        test_operand_write();
        test_conflict();
        test_busy_strobe();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_abc_responder.md
Name: mem_abc_responder

Overview:
- Memory-side responder for the SUBLEQ ABC datapath.
- Services the three request strobes issued by the CPU control decoder:
  - instruction fetch of A, B, C at PC, PC+1, PC+2;
  - operand fetch of mem[A] and mem[B];
  - writeback of the result to mem[B].
- Backing store is a single-port word array, so multi-word requests are serialized by an internal FSM, which signals completion with a done pulse.
- Also provides a preload port used by benches and boot logic.

Parameters:
- DATA_W, 16, word width of memory and all data ports
- ADDR_W, 8, address width; depth is fixed at 2^ADDR_W words

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- read_en_abc  input  1  request: fetch mem[pc], mem[pc+1], mem[pc+2]
- read_en_ab  input  1  request: fetch mem[addr_a], mem[addr_b]
- write_en_b  input  1  request: write wdata to mem[addr_b]
- pc  input  ADDR_W  fetch base address
- addr_a  input  ADDR_W  operand A address
- addr_b  input  ADDR_W  operand B / writeback address
- wdata  input  DATA_W  writeback data
- init_we  input  1  preload write strobe
- init_addr  input  ADDR_W  preload address
- init_data  input  DATA_W  preload data
- a_out  output  DATA_W  word at pc
- b_out  output  DATA_W  word at pc+1
- c_out  output  DATA_W  word at pc+2
- mem_a_out  output  DATA_W  mem[addr_a]
- mem_b_out  output  DATA_W  mem[addr_b]
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse flagging a dropped or conflicting request

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0.
  - Latched addresses and data cleared.
  - Array contents NOT reset; contents are retained across reset.
- Requests are sampled only on a rising edge while in IDLE. At that edge the responder latches pc, addr_a, addr_b and wdata as needed. Inputs may change afterwards.
- Priority when several strobes are high in IDLE: write_en_b > read_en_ab > read_en_abc. The highest-priority strobe is serviced, the others are dropped, and err pulses on the next cycle.
- Any strobe, including init_we, arriving while busy=1 is ignored, and err pulses on the next cycle.
- init_we behaviour:
  - In IDLE with no other strobe: array[init_addr] <= init_data at that edge. No done pulse, state stays IDLE.
  - With any other strobe in the same cycle: init_we is dropped and err pulses.
- States: IDLE, F0, F1, F2, O0, O1, W0.
- Fetch (edge 0 = request edge):
  - edge0: base <= pc; go to F0.
  - edge1: a_out <= mem[base]; go to F1.
  - edge2: b_out <= mem[base+1]; go to F2.
  - edge3: c_out <= mem[base+2]; done <= 1; go to IDLE.
  - base+1 and base+2 wrap modulo 2^ADDR_W.
- Operand read:
  - edge0: latch addr_a and addr_b; go to O0.
  - edge1: mem_a_out <= mem[la]; go to O1.
  - edge2: mem_b_out <= mem[lb]; done <= 1; go to IDLE.
  - If addr_a == addr_b, both outputs return the same word.
- Write:
  - edge0: latch addr_b and wdata; go to W0.
  - edge1: mem[lb] <= wdata; done <= 1; go to IDLE.
- Array reads are combinational from the array, registered into the output registers.
- Output registers hold their values until next overwritten or until reset.
- done is high for exactly one cycle, the cycle in which the state is back in IDLE. A new request may be sampled on that same edge-following cycle, i.e. done and busy are never high simultaneously.
- busy is a pure decode of the state register.
- Reset mid-operation: the transaction is aborted with no done pulse. If reset asserts before edge1 of a write, no write occurs. Partially updated output registers are cleared to 0.

Test Plan:
- Fetch: preload mem[10]=3, mem[11]=7, mem[12]=20; 1-cycle read_en_abc with pc=10 → a/b/c = 3/7/20; busy high for 3 cycles; done high exactly 3 edges after the request edge; err=0.
- Wrap: preload mem[255]=1, mem[0]=2, mem[1]=4; fetch with pc=255 → a/b/c = 1/2/4.
- Operand read, then write, then read-back:
  - mem[3]=5, mem[7]=9; read_en_ab with addr_a=3, addr_b=7 → mem_a_out=5, mem_b_out=9; done 2 edges after the request.
  - write_en_b with addr_b=7, wdata=0xFFFC → done 1 edge later.
  - read_en_ab with addr_a=addr_b=7 → both outputs 0xFFFC.
- Conflicts:
  - read_en_ab and write_en_b in the same cycle → only the write is performed; err pulses once; mem_a_out unchanged.
  - read_en_abc pulsed during F1 → ignored; err pulses; the fetch completes normally.
  - init_we while busy → array unchanged.
- Reset mid-operation:
  - Assert rst asynchronously in F1 → outputs 0, busy=0, no done pulse.
  - A subsequent fetch returns the preloaded data unchanged.
  - rst during W0 before the clock edge → target word keeps its old value.
